id_decode_stage: RTL and testbench
==================================

# id_decode_stage

Registered instruction-decode pipeline stage for the RV32 core. It sits between the IF/ID boundary and EX. Each accepted instruction is decoded into the team's standard control bundle and captured in an output register, with valid/ready handshakes on both sides. Compared with the flat combinational decoder, it adds optional RV32M decode, illegal-instruction detection, load-use hazard stalling with bubble insertion, and pipeline flush.

## Interface
- `XLEN`, 32: datapath and immediate width; the immediate is sign-extended to `XLEN`.
- `EN_M`, 1: 1 = decode RV32M (funct7 = 0000001 on R_type); 0 = treat those encodings as illegal.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill the held and incoming instruction (branch/jump redirect from EX).
- `in_valid`  in  1  upstream holds an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `in_instr`  in  32  raw instruction.
- `in_pc`  in  XLEN  PC of the instruction.
- `out_valid`  out  1  output register holds a live instruction.
- `out_ready`  in  1  EX consumes this cycle.
- `out_pc`  out  XLEN  registered PC.
- `out_imme`  out  XLEN  registered immediate (I/U/J/B/S formats; 0 otherwise).
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices.
- `out_alu_op`  out  4  ALU code from `define.v` (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
- `out_md_en`  out  1  RV32M operation; `out_alu_op` is don't-care when set.
- `out_md_op`  out  3  funct3 of the M operation (mul … remu).
- `out_funct3`  out  3  registered funct3, for branch and load/store width.
- `out_ctrl`  out  11  {jal, jalr, branch, auipc, reg_wen, mem_wen, mem_ren, ALU_DB_Src, Reg_Src[1:0], ebreak}.
- `out_illegal`  out  1  undecodable instruction.

## Operation
- Decode is combinational from `in_instr`. Decode rules:
  - `Reg_Src` encoding: 00 = ALU, 01 = mem, 10 = PC, 11 = imm.
  - B_type `alu_op`: SLTU if funct3[1] = 1, else SLT.
  - load/store/auipc `alu_op`: ADD.
  - R_type funct3 = 000: funct7[5] selects SUB.
  - I_type funct3 = 000: always ADD.
  - funct3 = 101: funct7[5] selects SRA.
  - `reg_wen` = 0 for store, B_type, illegal instructions, and instructions with rd = 0.
- M decode applies when `EN_M` = 1, opcode = R_type and funct7 = 0000001. It sets `md_en` = 1 and `md_op` = funct3.
- Illegal when any of the following hold. An illegal instruction has every side-effect control forced to 0 (`reg_wen`, `mem_wen`, `mem_ren`, `jal`, `jalr`, `branch`) but is still passed to EX with `out_illegal` = 1.
  - Opcode is not one of R, I, load, store, B, jal, jalr, lui, auipc, system.
  - R_type funct7 is not in {0000000, 0100000} (plus 0000001 when `EN_M` = 1).
  - I_type shift has a bad funct7.
- Register use:
  - `uses_rs1` = all opcodes except lui, auipc, jal.
  - `uses_rs2` = R, B, store.
- Load-use hazard: `hz` = `out_valid` & `out_mem_ren` & ~`out_mem_wen` & (`out_rd` ≠ 0) & ((`uses_rs1` & rs1 = `out_rd`) | (`uses_rs2` & rs2 = `out_rd`)).
- `in_ready` = ~`flush` & ~`hz` & (~`out_valid` | `out_ready`).
- Register update priority, highest first:
  1. `rst`: `out_valid` ← 0 and every `out_*` ← 0.
  2. `flush`: `out_valid` ← 0; fields hold; no instruction accepted.
  3. `in_valid` & `in_ready`: capture the decoded bundle; `out_valid` ← 1.
  4. `out_ready` & `out_valid`: `out_valid` ← 0. This covers the bubble on a hazard.
  5. Otherwise hold.
- Output fields never change while `out_valid` = 1 and `out_ready` = 0 (stable under backpressure).

## Timing
- Latency is 1 cycle from an accepted `in_instr` to `out_valid`.
- Throughput is 1 instruction/cycle with no hazard.
- A load-use hazard costs exactly 1 bubble cycle. The consumer is accepted in the cycle after the load leaves.
- `in_ready` is combinational from `flush`, `out_valid`, `out_ready` and `in_instr`. `in_valid` must not depend on `in_ready`.
- `flush` asserted together with `in_valid`: the instruction is dropped; the next cycle shows `out_valid` = 0.
- `rst` mid-stall or mid-backpressure: next cycle `out_valid` = 0 and `in_ready` = 1 (when `flush` = 0).
- rd = 0 loads never stall.

## Test plan
- **Reset:** `rst` = 1 for 2 cycles, then `in_valid` = 0 → `out_valid` = 0, all outputs 0, `in_ready` = 1.
- **Back-to-back:** add x1,x2,x3 (0x003100B3) then sub (0x403100B3), `out_ready` = 1 → outputs on consecutive cycles with `alu_op` ADD then SUB and `reg_wen` = 1.
- **Load-use:** lw x5,0(x1) then add x6,x5,x2 → one cycle with `out_valid` = 0 between them, `in_ready` = 0 during the bubble; with lw x0 instead there is no bubble.
- **M extension:** mul x1,x2,x3 (0x023100B3) → `EN_M` = 1 gives `md_en` = 1, `md_op` = 000; `EN_M` = 0 gives `out_illegal` = 1 and `reg_wen` = 0.
- **Backpressure and flush:** `out_ready` = 0 for 3 cycles → `out_*` stable and `in_ready` = 0; then `flush` = 1 together with `in_valid` → next cycle `out_valid` = 0 and the flushed instruction never appears.
- **Immediates:** jal (0xFFDFF06F), beq with negative offset, sw, lui → `out_imme` = 0xFFFFFFFC, the correct B/S sign-extension, and {imm[31:12], 12'h0} respectively.

Source files
------------

// File: rtl/id_decode_stage.sv
// RV32 instruction-decode pipeline stage: combinational decode into a registered
// control bundle with valid/ready handshakes, load-use stall, and flush.
module id_decode_stage #(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imme,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [3:0]      out_alu_op,
    output logic            out_md_en,
    output logic [2:0]      out_md_op,
    output logic [2:0]      out_funct3,
    output logic [10:0]     out_ctrl,
    output logic            out_illegal
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // funct3 -> ALU code; alt (funct7[5]) picks SUB on 000 and SRA on 101
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            3'b111:  arith_op = ALU_AND;
            default: arith_op = ALU_ADD;
        endcase
    endfunction

    logic [6:0]      opcode_s, funct7_s;
    logic [2:0]      funct3_s;
    logic [4:0]      rs1_s, rs2_s, rd_s;
    logic [31:0]     imm_i_s, imm_st_s, imm_b_s, imm_u_s, imm_j_s, imm32_s;
    logic [XLEN-1:0] imme_s;
    logic            jal_s, jalr_s, branch_s, auipc_s, reg_wen_s, mem_wen_s, mem_ren_s;
    logic            db_src_s, ebreak_s, illegal_s, md_en_s, uses_rs1_s, uses_rs2_s, hz_s;
    logic [1:0]      reg_src_s;
    logic [3:0]      alu_op_s;
    logic [2:0]      md_op_s;
    logic [10:0]     ctrl_s;

    assign opcode_s = in_instr[6:0];
    assign rd_s     = in_instr[11:7];
    assign funct3_s = in_instr[14:12];
    assign rs1_s    = in_instr[19:15];
    assign rs2_s    = in_instr[24:20];
    assign funct7_s = in_instr[31:25];

    assign imm_i_s  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_st_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b_s  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u_s  = {in_instr[31:12], 12'h000};
    assign imm_j_s  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imme_s   = XLEN'($signed(imm32_s));

    // Opcode decode into raw control fields, immediate select and legality
    always_comb begin
        alu_op_s   = ALU_ADD;
        md_en_s    = 1'b0;
        md_op_s    = 3'b000;
        jal_s      = 1'b0;
        jalr_s     = 1'b0;
        branch_s   = 1'b0;
        auipc_s    = 1'b0;
        reg_wen_s  = 1'b0;
        mem_wen_s  = 1'b0;
        mem_ren_s  = 1'b0;
        db_src_s   = 1'b0;
        reg_src_s  = 2'b00;
        ebreak_s   = 1'b0;
        illegal_s  = 1'b0;
        imm32_s    = 32'h0000_0000;
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b0;
        case (opcode_s)
            OP_R: begin
                uses_rs2_s = 1'b1;
                reg_wen_s  = 1'b1;
                alu_op_s   = arith_op(funct3_s, funct7_s[5]);
                md_en_s    = EN_M && (funct7_s == F7_M);
                md_op_s    = md_en_s ? funct3_s : 3'b000;
                illegal_s  = !((funct7_s == F7_BASE) || (funct7_s == F7_ALT) || md_en_s);
            end
            OP_I: begin
                reg_wen_s = 1'b1;
                db_src_s  = 1'b1;
                imm32_s   = imm_i_s;
                alu_op_s  = (funct3_s == 3'b000) ? ALU_ADD : arith_op(funct3_s, funct7_s[5]);
                // shift-immediate encodings only allow the base or SRA funct7
                illegal_s = ((funct3_s == 3'b001) && (funct7_s != F7_BASE)) ||
                            ((funct3_s == 3'b101) && (funct7_s != F7_BASE) && (funct7_s != F7_ALT));
            end
            OP_LOAD: begin
                reg_wen_s = 1'b1;
                mem_ren_s = 1'b1;
                db_src_s  = 1'b1;
                reg_src_s = 2'b01;
                imm32_s   = imm_i_s;
            end
            OP_STORE: begin
                uses_rs2_s = 1'b1;
                mem_wen_s  = 1'b1;
                db_src_s   = 1'b1;
                imm32_s    = imm_st_s;
            end
            OP_BRANCH: begin
                uses_rs2_s = 1'b1;
                branch_s   = 1'b1;
                alu_op_s   = funct3_s[1] ? ALU_SLTU : ALU_SLT;
                imm32_s    = imm_b_s;
            end
            OP_JAL: begin
                uses_rs1_s = 1'b0;
                jal_s      = 1'b1;
                reg_wen_s  = 1'b1;
                reg_src_s  = 2'b10;
                imm32_s    = imm_j_s;
            end
            OP_JALR: begin
                jalr_s    = 1'b1;
                reg_wen_s = 1'b1;
                db_src_s  = 1'b1;
                reg_src_s = 2'b10;
                imm32_s   = imm_i_s;
            end
            OP_LUI: begin
                uses_rs1_s = 1'b0;
                reg_wen_s  = 1'b1;
                reg_src_s  = 2'b11;
                imm32_s    = imm_u_s;
            end
            OP_AUIPC: begin
                uses_rs1_s = 1'b0;
                auipc_s    = 1'b1;
                reg_wen_s  = 1'b1;
                db_src_s   = 1'b1;
                imm32_s    = imm_u_s;
            end
            OP_SYSTEM: begin
                ebreak_s = (in_instr == 32'h0010_0073);
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // illegal instructions travel to EX with every side effect suppressed
    assign ctrl_s = {jal_s & ~illegal_s, jalr_s & ~illegal_s, branch_s & ~illegal_s, auipc_s,
                     reg_wen_s & ~illegal_s & (rd_s != 5'd0), mem_wen_s & ~illegal_s,
                     mem_ren_s & ~illegal_s, db_src_s, reg_src_s, ebreak_s};

    assign hz_s = out_valid & out_ctrl[4] & ~out_ctrl[5] & (out_rd != 5'd0) &
                  ((uses_rs1_s & (rs1_s == out_rd)) | (uses_rs2_s & (rs2_s == out_rd)));

    assign in_ready = ~flush & ~hz_s & (~out_valid | out_ready);

    // Output register: reset, flush, capture, drain, hold in priority order
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= {XLEN{1'b0}};
            out_imme    <= {XLEN{1'b0}};
            out_rs1     <= 5'd0;
            out_rs2     <= 5'd0;
            out_rd      <= 5'd0;
            out_alu_op  <= 4'd0;
            out_md_en   <= 1'b0;
            out_md_op   <= 3'd0;
            out_funct3  <= 3'd0;
            out_ctrl    <= 11'd0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_imme    <= imme_s;
            out_rs1     <= rs1_s;
            out_rs2     <= rs2_s;
            out_rd      <= rd_s;
            out_alu_op  <= alu_op_s;
            out_md_en   <= md_en_s;
            out_md_op   <= md_op_s;
            out_funct3  <= funct3_s;
            out_ctrl    <= ctrl_s;
            out_illegal <= illegal_s;
        end else if (out_ready && out_valid) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end
endmodule

// File: tb/tb_id_decode_stage.sv
// Directed-vector bench for id_decode_stage: one instance with RV32M decode and
// one without, driven from a shared stimulus stream.
module tb_id_decode_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready, out_valid, out_md_en, out_illegal;
    logic [31:0] out_pc, out_imme;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [3:0]  out_alu_op;
    logic [2:0]  out_md_op, out_funct3;
    logic [10:0] out_ctrl;

    logic        nm_in_ready, nm_out_valid, nm_out_md_en, nm_out_illegal;
    logic [31:0] nm_out_pc, nm_out_imme;
    logic [4:0]  nm_out_rs1, nm_out_rs2, nm_out_rd;
    logic [3:0]  nm_out_alu_op;
    logic [2:0]  nm_out_md_op, nm_out_funct3;
    logic [10:0] nm_out_ctrl;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    id_decode_stage #(.XLEN(32), .EN_M(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imme(out_imme), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_alu_op(out_alu_op), .out_md_en(out_md_en), .out_md_op(out_md_op),
        .out_funct3(out_funct3), .out_ctrl(out_ctrl), .out_illegal(out_illegal)
    );

    id_decode_stage #(.XLEN(32), .EN_M(1'b0)) dut_nm (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(nm_out_valid), .out_ready(out_ready),
        .out_pc(nm_out_pc), .out_imme(nm_out_imme), .out_rs1(nm_out_rs1), .out_rs2(nm_out_rs2),
        .out_rd(nm_out_rd), .out_alu_op(nm_out_alu_op), .out_md_en(nm_out_md_en), .out_md_op(nm_out_md_op),
        .out_funct3(nm_out_funct3), .out_ctrl(nm_out_ctrl), .out_illegal(nm_out_illegal)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0000_0000; in_pc = 32'h0000_0000;
        cyc; cyc;
        rst = 1'b0;
        cyc;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %0h exp 0", out_valid); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
        vecs++; if ({out_pc, out_imme} !== 64'h0) begin errs++; $display("FAIL reset_pc_imme got %h %h exp 0 0", out_pc, out_imme); end
        vecs++; if ({out_rs1, out_rs2, out_rd, out_alu_op, out_md_en, out_md_op, out_funct3, out_ctrl, out_illegal} !== 40'h0)
            begin errs++; $display("FAIL reset_fields got ctrl=%h alu=%h rd=%h exp all 0", out_ctrl, out_alu_op, out_rd); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        issue(32'h0031_00B3, 32'h0000_0100);
        cyc;
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL b2b_add_valid got %0h exp 1", out_valid); end
        vecs++; if (out_alu_op !== 4'd0) begin errs++; $display("FAIL b2b_add_alu got %0d exp 0", out_alu_op); end
        vecs++; if (out_ctrl !== 11'h040) begin errs++; $display("FAIL b2b_add_ctrl got %h exp 040", out_ctrl); end
        vecs++; if ({out_rd, out_rs1, out_rs2} !== {5'd1, 5'd2, 5'd3}) begin errs++; $display("FAIL b2b_add_regs got %0d %0d %0d exp 1 2 3", out_rd, out_rs1, out_rs2); end
        issue(32'h4031_00B3, 32'h0000_0104);
        cyc;
        vecs++; if (out_alu_op !== 4'd1) begin errs++; $display("FAIL b2b_sub_alu got %0d exp 1", out_alu_op); end
        vecs++; if ({out_valid, out_pc} !== {1'b1, 32'h0000_0104}) begin errs++; $display("FAIL b2b_sub_pc got %0h %h exp 1 00000104", out_valid, out_pc); end
        vecs++; if (out_ctrl !== 11'h040) begin errs++; $display("FAIL b2b_sub_ctrl got %h exp 040", out_ctrl); end
        in_valid = 1'b0;
        cyc;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain got %0h exp 0", out_valid); end
    endtask

    task automatic test_load_use;
        issue(32'h0000_A283, 32'h0000_0200);
        cyc;
        vecs++; if (out_ctrl !== 11'h05A) begin errs++; $display("FAIL lu_lw_ctrl got %h exp 05A", out_ctrl); end
        issue(32'h0022_8333, 32'h0000_0204);
        #1;
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL lu_stall_ready got %0h exp 0", in_ready); end
        cyc;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL lu_bubble_valid got %0h exp 0", out_valid); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL lu_after_bubble_ready got %0h exp 1", in_ready); end
        cyc;
        vecs++; if ({out_valid, out_rd, out_rs1, out_pc} !== {1'b1, 5'd6, 5'd5, 32'h0000_0204})
            begin errs++; $display("FAIL lu_consumer got v=%0h rd=%0d rs1=%0d pc=%h exp 1 6 5 00000204", out_valid, out_rd, out_rs1, out_pc); end
        in_valid = 1'b0;
        cyc;
        issue(32'h0000_A003, 32'h0000_0210);
        cyc;
        vecs++; if (out_ctrl !== 11'h01A) begin errs++; $display("FAIL lu_lwx0_ctrl got %h exp 01A", out_ctrl); end
        issue(32'h0020_0333, 32'h0000_0214);
        #1;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL lu_x0_ready got %0h exp 1", in_ready); end
        cyc;
        vecs++; if ({out_valid, out_rd, out_pc} !== {1'b1, 5'd6, 32'h0000_0214})
            begin errs++; $display("FAIL lu_x0_no_bubble got v=%0h rd=%0d pc=%h exp 1 6 00000214", out_valid, out_rd, out_pc); end
        in_valid = 1'b0;
        cyc;
    endtask

    task automatic test_m_ext;
        issue(32'h0231_00B3, 32'h0000_0300);
        cyc;
        vecs++; if ({out_md_en, out_md_op, out_illegal} !== {1'b1, 3'd0, 1'b0}) begin errs++; $display("FAIL m_mul_on got md_en=%0h md_op=%0h ill=%0h exp 1 0 0", out_md_en, out_md_op, out_illegal); end
        vecs++; if (out_ctrl !== 11'h040) begin errs++; $display("FAIL m_mul_on_ctrl got %h exp 040", out_ctrl); end
        vecs++; if ({nm_out_illegal, nm_out_md_en, nm_out_ctrl} !== {1'b1, 1'b0, 11'h000}) begin errs++; $display("FAIL m_mul_off got ill=%0h md_en=%0h ctrl=%h exp 1 0 000", nm_out_illegal, nm_out_md_en, nm_out_ctrl); end
        vecs++; if ({nm_out_valid, nm_out_pc, nm_out_imme, nm_out_rd, nm_out_rs1, nm_out_rs2, nm_out_alu_op, nm_out_md_op, nm_out_funct3} !==
                    {1'b1, 32'h0000_0300, 32'h0, 5'd1, 5'd2, 5'd3, 4'd0, 3'd0, 3'd0})
            begin errs++; $display("FAIL m_mul_off_fields got v=%0h pc=%h imm=%h rd=%0d alu=%0d f3=%0d", nm_out_valid, nm_out_pc, nm_out_imme, nm_out_rd, nm_out_alu_op, nm_out_funct3); end
        issue(32'h0231_70B3, 32'h0000_0304);
        cyc;
        vecs++; if ({out_md_en, out_md_op, out_funct3} !== {1'b1, 3'd7, 3'd7}) begin errs++; $display("FAIL m_remu got md_en=%0h md_op=%0h f3=%0h exp 1 7 7", out_md_en, out_md_op, out_funct3); end
        vecs++; if ({nm_out_illegal, nm_in_ready} !== {1'b1, 1'b1}) begin errs++; $display("FAIL m_remu_off got ill=%0h rdy=%0h exp 1 1", nm_out_illegal, nm_in_ready); end
        in_valid = 1'b0;
        cyc;
    endtask

    task automatic test_backpressure_flush;
        out_ready = 1'b0;
        issue(32'h0031_00B3, 32'h0000_0400);
        cyc;
        issue(32'h0031_60B3, 32'h0000_0404);
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready[%0d] got %0h exp 0", i, in_ready); end
            cyc;
            vecs++; if ({out_valid, out_pc, out_alu_op, out_ctrl} !== {1'b1, 32'h0000_0400, 4'd0, 11'h040})
                begin errs++; $display("FAIL bp_stable[%0d] got v=%0h pc=%h alu=%0d ctrl=%h exp 1 00000400 0 040", i, out_valid, out_pc, out_alu_op, out_ctrl); end
        end
        flush = 1'b1;
        cyc;
        vecs++; if ({out_valid, out_pc} !== {1'b0, 32'h0000_0400}) begin errs++; $display("FAIL flush_kill got v=%0h pc=%h exp 0 00000400", out_valid, out_pc); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_never_appears got %0h exp 0", out_valid); end
        out_ready = 1'b0;
        issue(32'h0031_00B3, 32'h0000_0440);
        cyc;
        in_valid = 1'b0; rst = 1'b1;
        cyc;
        rst = 1'b0;
        #1;
        vecs++; if ({out_valid, in_ready, out_pc} !== {1'b0, 1'b1, 32'h0}) begin errs++; $display("FAIL rst_mid_bp got v=%0h rdy=%0h pc=%h exp 0 1 0", out_valid, in_ready, out_pc); end
        out_ready = 1'b1;
    endtask

    task automatic test_immediates;
        issue(32'hFFDF_F06F, 32'h0000_0500);
        cyc;
        vecs++; if ({out_imme, out_ctrl} !== {32'hFFFF_FFFC, 11'h404}) begin errs++; $display("FAIL imm_jal got %h ctrl=%h exp FFFFFFFC 404", out_imme, out_ctrl); end
        issue(32'hFE20_8CE3, 32'h0000_0504);
        cyc;
        vecs++; if ({out_imme, out_ctrl, out_alu_op} !== {32'hFFFF_FFF8, 11'h100, 4'd3}) begin errs++; $display("FAIL imm_beq got %h ctrl=%h alu=%0d exp FFFFFFF8 100 3", out_imme, out_ctrl, out_alu_op); end
        issue(32'hFE20_AE23, 32'h0000_0508);
        cyc;
        vecs++; if ({out_imme, out_ctrl} !== {32'hFFFF_FFFC, 11'h028}) begin errs++; $display("FAIL imm_sw_neg got %h ctrl=%h exp FFFFFFFC 028", out_imme, out_ctrl); end
        issue(32'h0020_AA23, 32'h0000_050C);
        cyc;
        vecs++; if (out_imme !== 32'h0000_0014) begin errs++; $display("FAIL imm_sw_pos got %h exp 00000014", out_imme); end
        issue(32'h1234_52B7, 32'h0000_0510);
        cyc;
        vecs++; if ({out_imme, out_ctrl, out_rd} !== {32'h1234_5000, 11'h046, 5'd5}) begin errs++; $display("FAIL imm_lui got %h ctrl=%h rd=%0d exp 12345000 046 5", out_imme, out_ctrl, out_rd); end
        in_valid = 1'b0;
        cyc;
    endtask

    task automatic test_illegal;
        issue(32'h0000_007F, 32'h0000_0600);
        cyc;
        vecs++; if ({out_illegal, out_ctrl} !== {1'b1, 11'h000}) begin errs++; $display("FAIL ill_opcode got ill=%0h ctrl=%h exp 1 000", out_illegal, out_ctrl); end
        issue(32'h4010_9093, 32'h0000_0604);
        cyc;
        vecs++; if ({out_illegal, out_ctrl} !== {1'b1, 11'h008}) begin errs++; $display("FAIL ill_slli got ill=%0h ctrl=%h exp 1 008", out_illegal, out_ctrl); end
        issue(32'h4010_D093, 32'h0000_0608);
        cyc;
        vecs++; if ({out_illegal, out_alu_op, out_ctrl} !== {1'b0, 4'd7, 11'h048}) begin errs++; $display("FAIL srai_legal got ill=%0h alu=%0d ctrl=%h exp 0 7 048", out_illegal, out_alu_op, out_ctrl); end
        in_valid = 1'b0;
        cyc;
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_load_use;
        test_m_ext;
        test_backpressure_flush;
        test_immediates;
        test_illegal;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
